// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl
// Description : Memory-mapped 8N1 serial controller. One TX holding register
//               feeding a TX shifter, and an RX deserialiser feeding a
//               circular RX FIFO. The rx-not-empty interrupt is registered.
//
// Ports       : clk, rst          - clock and synchronous active-high reset
//               enable_i          - one-cycle access strobe
//               readEnable_i      - 1 = read, 0 = write
//               addr_i            - only bit 2 decoded (0 = DATA, 1 = STATUS)
//               dataSave_i        - write data, bits [7:0] used
//               dataLoad_o        - combinational read data
//               busy_o            - stall while a DATA write waits for TX hold
//               int_o             - high while the RX FIFO holds data
//               rxd / txd         - serial input (async) / output (idles high)
//
// STATUS      : {28'h0, frame_err, overrun, tx_ready, rx_avail}
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        busy_o,
    output logic        int_o,
    input  logic        rxd,
    output logic        txd
);

    localparam int c_DIV  = CLK_FREQ / BAUD;
    localparam int c_HALF = c_DIV / 2;
    localparam int c_CW   = $clog2(c_DIV);
    localparam int c_AW   = $clog2(RX_DEPTH);
    localparam int c_NW   = c_AW + 1;

    localparam logic [c_CW-1:0] c_DIV_LAST  = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_HALF - 1);
    localparam logic [c_NW-1:0] c_DEPTH_N   = c_NW'(RX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic              r_hold_full;
    logic [7:0]        r_hold;

    tx_state_t         r_tx_state, w_tx_state_n;
    logic [c_CW-1:0]   r_tx_cnt,   w_tx_cnt_n;
    logic [2:0]        r_tx_bit,   w_tx_bit_n;
    logic [7:0]        r_tx_shift, w_tx_shift_n;
    logic              r_txd,      w_txd_n;
    logic              w_tx_take;
    logic              w_tx_tick;

    logic              r_rx_meta, r_rx_sync, r_rx_prev;
    logic              w_rx_fall;
    rx_state_t         r_rx_state, w_rx_state_n;
    logic [c_CW-1:0]   r_rx_cnt,   w_rx_cnt_n;
    logic [2:0]        r_rx_bit,   w_rx_bit_n;
    logic [7:0]        r_rx_shift, w_rx_shift_n;
    logic              w_rx_push;
    logic              w_rx_ferr;

    logic [7:0]        r_mem [RX_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_NW-1:0]   r_count;
    logic              w_rx_avail, w_fifo_full, w_fifo_wr, w_pop, w_ovr_set;
    logic [7:0]        w_head;

    logic              r_overrun, r_frame_err, r_int;

    logic              w_is_status, w_data_wr_req, w_access;
    logic              w_data_wr, w_data_rd, w_stat_rd;
    logic              w_unused;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_is_status   = addr_i[2];
    assign w_data_wr_req = enable_i & ~readEnable_i & ~w_is_status;

    // A write may complete on the very edge the TX FSM takes the held byte,
    // so the stall drops in that cycle rather than one cycle later.
    assign busy_o    = w_data_wr_req & r_hold_full & ~w_tx_take;
    assign w_access  = enable_i & ~busy_o;
    assign w_data_wr = w_access & ~readEnable_i & ~w_is_status;
    assign w_data_rd = w_access &  readEnable_i & ~w_is_status;
    assign w_stat_rd = w_access &  readEnable_i &  w_is_status;

    assign w_unused = ^{addr_i[31:3], addr_i[1:0], dataSave_i[31:8]};

    always_comb begin
        dataLoad_o = 32'h0;
        if (w_is_status) begin
            dataLoad_o = {28'h0, r_frame_err, r_overrun, ~r_hold_full, w_rx_avail};
        end else if (w_rx_avail) begin
            dataLoad_o = {24'h0, w_head};
        end
    end

    // ------------------------------------------------------------------
    // TX holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold      <= 8'h0;
        end else if (w_data_wr) begin
            r_hold_full <= 1'b1;
            r_hold      <= dataSave_i[7:0];
        end else if (w_tx_take) begin
            r_hold_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    assign w_tx_tick = (r_tx_cnt == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_txd      <= w_txd_n;
        end
    end

    // txd is registered from the next-state values so the line changes on
    // the same edge as the state.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + c_CW'(1);
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_txd_n      = r_txd;
        w_tx_take    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_n = '0;
                w_txd_n    = 1'b1;
                if (r_hold_full) begin
                    w_tx_take    = 1'b1;
                    w_tx_shift_n = r_hold;
                    w_txd_n      = 1'b0;
                    w_tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (w_tx_tick) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = 3'd0;
                    w_txd_n      = r_tx_shift[0];
                    w_tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tx_tick) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_txd_n      = 1'b1;
                        w_tx_state_n = TX_STOP;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 3'd1;
                        w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        w_txd_n      = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_tick) begin
                    w_tx_cnt_n = '0;
                    // A refilled holding register chains straight into the
                    // next start bit with no idle gap.
                    if (r_hold_full) begin
                        w_tx_take    = 1'b1;
                        w_tx_shift_n = r_hold;
                        w_txd_n      = 1'b0;
                        w_tx_state_n = TX_START;
                    end else begin
                        w_txd_n      = 1'b1;
                        w_tx_state_n = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_cnt_n   = '0;
                w_txd_n      = 1'b1;
                w_tx_state_n = TX_IDLE;
            end
        endcase
    end

    assign txd = r_txd;

    // ------------------------------------------------------------------
    // RX synchroniser and falling-edge detect (reset to idle-high)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    // The START half-bit delay puts every later sample near mid-bit. The
    // FSM returns to IDLE at mid stop bit so a following frame's start edge
    // is not missed.
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt + c_CW'(1);
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_push    = 1'b0;
        w_rx_ferr    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_n = '0;
                if (w_rx_fall) begin
                    w_rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_n = '0;
                    if (r_rx_sync) begin
                        w_rx_state_n = RX_IDLE;
                    end else begin
                        w_rx_bit_n   = 3'd0;
                        w_rx_state_n = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_DIV_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_n = RX_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_DIV_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_push    = r_rx_sync;
                    w_rx_ferr    = ~r_rx_sync;
                    w_rx_state_n = RX_IDLE;
                end
            end
            default: begin
                w_rx_cnt_n   = '0;
                w_rx_state_n = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    assign w_rx_avail  = (r_count != '0);
    assign w_fifo_full = (r_count == c_DEPTH_N);
    assign w_pop       = w_data_rd & w_rx_avail;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign w_fifo_wr   = w_rx_push & (~w_fifo_full | w_pop);
    assign w_ovr_set   = w_rx_push & w_fifo_full & ~w_pop;
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_fifo_wr && !w_pop) begin
                r_count <= r_count + c_NW'(1);
            end else if (w_pop && !w_fifo_wr) begin
                r_count <= r_count - c_NW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors and interrupt. A new error on the clearing edge wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_int       <= 1'b0;
        end else begin
            r_overrun   <= (r_overrun   & ~w_stat_rd) | w_ovr_set;
            r_frame_err <= (r_frame_err & ~w_stat_rd) | w_rx_ferr;
            r_int       <= w_rx_avail;
        end
    end

    assign int_o = r_int;

endmodule
`default_nettype wire
